// File: rtl/function_inv_search.sv
// rtl/function_inv_search.sv - inverse search of f(x) = x*|x| by successive approximation
//
// Purpose:
//   Accepts a signed target value yiq and finds the largest signed argument x
//   with f(x) = x*|x| <= target. The search runs one bit per cycle, MSB first,
//   on the offset code u = x + 2^(W_X-1). Because f is monotonic in x and x is
//   monotonic in u, a plain binary search on u is exact.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - yiq carries a target
//   in_ready   - block is idle and can take a target
//   yiq        - signed target value (W_Y bits)
//   out_valid  - result fields valid, held until out_ready
//   out_ready  - consumer takes the result
//   xiq        - recovered signed argument (W_X bits)
//   exact      - f(xiq) equals the target
//   under      - target below f(x_min)
//   over       - target above f(x_max)

module function_inv_search #(
  parameter int W_X = 4,
  parameter int W_Y = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W_Y-1:0] yiq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W_X-1:0] xiq,
  output logic                  exact,
  output logic                  under,
  output logic                  over
);

  localparam int FW = 2 * W_X;
  // Compare width: wide enough for both f(x) and the target, plus one bit so
  // neither side can overflow when sign-extended.
  localparam int CW = ((FW > W_Y) ? FW : W_Y) + 1;
  localparam logic [W_X-1:0] MSB = {1'b1, {(W_X-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [W_Y-1:0] target_q, target_d;
  logic [W_X-1:0]        cand_q, cand_d;
  logic [W_X-1:0]        bit_q, bit_d;
  logic signed [W_X-1:0] xiq_q, xiq_d;
  logic                  exact_q, exact_d;
  logic                  under_q, under_d;
  logic                  over_q, over_d;

  logic [W_X-1:0]        trial;
  logic [W_X-1:0]        final_u;
  logic signed [CW-1:0]  tgt_ext;
  logic                  keep;

  // f evaluated on an offset code. Flipping the MSB of u turns it back into
  // two's-complement x. The arithmetic runs at 2*W_X bits, so |x_min| is
  // representable and x_min*|x_min| is exact.
  function automatic logic signed [CW-1:0] f_of_code(input logic [W_X-1:0] u);
    logic signed [W_X-1:0] x;
    logic signed [FW-1:0]  xe;
    logic signed [FW-1:0]  ae;
    logic signed [FW-1:0]  p;
    x  = $signed(u ^ MSB);
    xe = {{W_X{x[W_X-1]}}, x};
    ae = xe[FW-1] ? -xe : xe;
    p  = xe * ae;
    return {{(CW-FW){p[FW-1]}}, p};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cand_q   <= '0;
      bit_q    <= '0;
      xiq_q    <= '0;
      exact_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cand_q   <= cand_d;
      bit_q    <= bit_d;
      xiq_q    <= xiq_d;
      exact_q  <= exact_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cand_d   = cand_q;
    bit_d    = bit_q;
    xiq_d    = xiq_q;
    exact_d  = exact_q;
    under_d  = under_q;
    over_d   = over_q;

    tgt_ext = {{(CW-W_Y){target_q[W_Y-1]}}, target_q};
    trial   = cand_q | bit_q;
    keep    = (f_of_code(trial) <= tgt_ext);
    final_u = keep ? trial : cand_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          target_d = yiq;
          cand_d   = '0;
          bit_d    = MSB;
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        cand_d = final_u;
        bit_d  = bit_q >> 1;
        // The LSB trial is the last one; its decision finishes the result.
        if (bit_q[0]) begin
          state_d = DONE;
          xiq_d   = $signed(final_u ^ MSB);
          exact_d = (f_of_code(final_u) == tgt_ext);
          under_d = (tgt_ext < f_of_code({W_X{1'b0}}));
          over_d  = (tgt_ext > f_of_code({W_X{1'b1}}));
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign xiq   = xiq_q;
  assign exact = exact_q;
  assign under = under_q;
  assign over  = over_q;

endmodule

// File: tb/tb_function_inv_search.sv
// tb/tb_function_inv_search.sv - directed testbench for function_inv_search

module tb_function_inv_search;

  localparam int W_X = 4;
  localparam int W_Y = 8;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W_Y-1:0] yiq;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W_X-1:0] xiq;
  logic                  exact;
  logic                  under;
  logic                  over;

  int tests_run;
  int tests_failed;

  function_inv_search #(.W_X(W_X), .W_Y(W_Y)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .yiq       (yiq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xiq       (xiq),
    .exact     (exact),
    .under     (under),
    .over      (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [7:0] y;
    logic signed [3:0] x;
    logic              e;
    logic              u;
    logic              o;
  } vec_t;

  // Hand-computed: f(-8)=-64, f(-4)=-16, f(-3)=-9, f(-1)=-1, f(0)=0,
  // f(1)=1, f(2)=4, f(3)=9, f(4)=16, f(7)=49.
  vec_t tbl [12] = '{
    '{ 8'sd9,    4'sd3,  1'b1, 1'b0, 1'b0},
    '{ 8'sd10,   4'sd3,  1'b0, 1'b0, 1'b0},
    '{-8'sd10,  -4'sd4,  1'b0, 1'b0, 1'b0},
    '{-8'sd16,  -4'sd4,  1'b1, 1'b0, 1'b0},
    '{-8'sd100, -4'sd8,  1'b0, 1'b1, 1'b0},
    '{ 8'sd100,  4'sd7,  1'b0, 1'b0, 1'b1},
    '{ 8'sd49,   4'sd7,  1'b1, 1'b0, 1'b0},
    '{ 8'sd0,    4'sd0,  1'b1, 1'b0, 1'b0},
    '{-8'sd64,  -4'sd8,  1'b1, 1'b0, 1'b0},
    '{-8'sd65,  -4'sd8,  1'b0, 1'b1, 1'b0},
    '{ 8'sd50,   4'sd7,  1'b0, 1'b0, 1'b1},
    '{ 8'sd2,    4'sd1,  1'b0, 1'b0, 1'b0}
  };

  // Offer a target and return once it has been taken (or the wait ran out).
  task automatic accept_target(input logic signed [W_Y-1:0] y, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = in_ready;
    in_valid = 1'b1;
    yiq = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, xiq, exact, under, over} !== {1'b1, 1'b0, 4'sd0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_state: got in_ready=%0b out_valid=%0b xiq=%0d e/u/o=%0b%0b%0b, want 1 0 0 000",
               in_ready, out_valid, xiq, exact, under, over);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    bit ok;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      accept_target(tbl[i].y, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL vec%0d_in_ready: in_ready stayed low, want 1", i);
      end
      wait_result(cyc);
      tests_run++;
      if (cyc !== W_X) begin
        tests_failed++;
        $display("FAIL vec%0d_latency: out_valid after %0d edges past accept, want %0d", i, cyc, W_X);
      end
      tests_run++;
      if (xiq !== tbl[i].x) begin
        tests_failed++;
        $display("FAIL vec%0d_xiq: yiq=%0d got %0d want %0d", i, tbl[i].y, xiq, tbl[i].x);
      end
      tests_run++;
      if ({exact, under, over} !== {tbl[i].e, tbl[i].u, tbl[i].o}) begin
        tests_failed++;
        $display("FAIL vec%0d_flags: yiq=%0d got e/u/o=%0b%0b%0b want %0b%0b%0b", i, tbl[i].y,
                 exact, under, over, tbl[i].e, tbl[i].u, tbl[i].o);
      end
      handshake();
      tests_run++;
      if ({in_ready, out_valid} !== 2'b10) begin
        tests_failed++;
        $display("FAIL vec%0d_after_handshake: in_ready=%0b out_valid=%0b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int cyc;
    accept_target(-8'sd10, ok);
    wait_result(cyc);
    tests_run++;
    if (!ok || cyc !== W_X) begin
      tests_failed++;
      $display("FAIL bp_start: ok=%0b latency=%0d want 1 %0d", ok, cyc, W_X);
    end
    // Inputs wiggle while the result is held; they must not disturb it.
    in_valid = 1'b1;
    yiq = 8'sd100;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, in_ready, xiq, exact, under, over} !== {1'b1, 1'b0, -4'sd4, 3'b000}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b xiq=%0d e/u/o=%0b%0b%0b want 1 0 -4 000",
                 k, out_valid, in_ready, xiq, exact, under, over);
      end
    end
    in_valid = 1'b0;
    handshake();
    tests_run++;
    if ({in_ready, out_valid, xiq} !== {1'b1, 1'b0, -4'sd4}) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b xiq=%0d want 1 0 -4", in_ready, out_valid, xiq);
    end
    // Fields keep the last result through the next search.
    accept_target(8'sd49, ok);
    @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready, xiq} !== {1'b0, 1'b0, -4'sd4}) begin
      tests_failed++;
      $display("FAIL bp_fields_kept: out_valid=%0b in_ready=%0b xiq=%0d want 0 0 -4", out_valid, in_ready, xiq);
    end
    wait_result(cyc);
    tests_run++;
    if (xiq !== 4'sd7 || cyc !== W_X - 1) begin
      tests_failed++;
      $display("FAIL bp_next_result: xiq=%0d remaining_edges=%0d want 7 %0d", xiq, cyc, W_X - 1);
    end
    handshake();
  endtask

  task automatic test_reset_mid_search();
    bit ok;
    bit seen;
    int cyc;
    accept_target(8'sd49, ok);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, xiq, exact, under, over} !== {1'b1, 1'b0, 4'sd0, 3'b000}) begin
      tests_failed++;
      $display("FAIL rst_mid_immediate: in_ready=%0b out_valid=%0b xiq=%0d e/u/o=%0b%0b%0b want 1 0 0 000",
               in_ready, out_valid, xiq, exact, under, over);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_result: out_valid rose for abandoned target, want never");
    end
    accept_target(8'sd10, ok);
    wait_result(cyc);
    tests_run++;
    if (!ok || cyc !== W_X || xiq !== 4'sd3 || exact !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_next: ok=%0b latency=%0d xiq=%0d exact=%0b want 1 %0d 3 0",
               ok, cyc, xiq, exact, W_X);
    end
    handshake();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    yiq       = '0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_vectors();
    test_back_pressure();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
